// File: rtl/serial_sub.sv
// serial_sub: bit-serial unsigned subtractor, LSB first.
// One full-subtractor cell plus a borrow flop computes a - b over WIDTH
// cycles behind a start/busy/done handshake. The result is offered both
// as a parallel word (diff, borrow_out) and as a qualified serial stream
// (diff_bit, diff_bit_vld).
module serial_sub #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             diff_bit,
    output logic             diff_bit_vld
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_br;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow_out;
    logic             r_diff_bit;
    logic             r_diff_bit_vld;

    logic             w_a0;
    logic             w_b0;
    logic             w_d;
    logic             w_br_next;
    logic             w_last;
    logic [WIDTH-1:0] w_res_next;

    // Full-subtractor cell on the current LSBs and the completed-result view.
    always_comb begin
        w_a0       = r_a[0];
        w_b0       = r_b[0];
        w_d        = w_a0 ^ w_b0 ^ r_br;
        w_br_next  = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_br);
        w_last     = (r_cnt == LAST_BIT);
        w_res_next = {w_d, r_res[WIDTH-1:1]};
    end

    // Control FSM with all datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_a            <= '0;
            r_b            <= '0;
            r_res          <= '0;
            r_br           <= 1'b0;
            r_cnt          <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_diff         <= '0;
            r_borrow_out   <= 1'b0;
            r_diff_bit     <= 1'b0;
            r_diff_bit_vld <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_br    <= 1'b0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_a            <= {1'b0, r_a[WIDTH-1:1]};
                    r_b            <= {1'b0, r_b[WIDTH-1:1]};
                    r_res          <= w_res_next;
                    r_br           <= w_br_next;
                    r_diff_bit     <= w_d;
                    r_diff_bit_vld <= 1'b1;
                    r_cnt          <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_diff       <= w_res_next;
                        r_borrow_out <= w_br_next;
                        r_done       <= 1'b1;
                        r_state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done         <= 1'b0;
                    r_busy         <= 1'b0;
                    r_diff_bit_vld <= 1'b0;
                    r_state        <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign diff         = r_diff;
    assign borrow_out   = r_borrow_out;
    assign diff_bit     = r_diff_bit;
    assign diff_bit_vld = r_diff_bit_vld;

endmodule

// File: tb/tb_serial_sub.sv
// Testbench for serial_sub (WIDTH = 8): table vectors, hand-written
// multi-cycle sequences and random operands against an arithmetic model.
module tb_serial_sub;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         diff_bit;
    logic         diff_bit_vld;

    int unsigned  n_pass;
    int unsigned  n_total;
    logic [W-1:0] last_diff;
    logic         last_borrow;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [W-1:0] exp_diff;
        logic         exp_borrow;
    } vec_t;

    vec_t vecs [5];

    serial_sub #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .a            (a),
        .b            (b),
        .busy         (busy),
        .done         (done),
        .diff         (diff),
        .borrow_out   (borrow_out),
        .diff_bit     (diff_bit),
        .diff_bit_vld (diff_bit_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " done"}, 32'(done), 0);
        check({tag, " diff"}, 32'(diff), 0);
        check({tag, " borrow_out"}, 32'(borrow_out), 0);
        check({tag, " diff_bit"}, 32'(diff_bit), 0);
        check({tag, " diff_bit_vld"}, 32'(diff_bit_vld), 0);
    endtask

    // Full operation from a start pulse at the next rising edge through the
    // return to IDLE, checking every cycle of the serial stream.
    task automatic run_op(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic [W-1:0] ed, input logic eb);
        @(negedge clk);
        a = va;
        b = vb;
        start = 1'b1;
        tick();                               // E0
        start = 1'b0;
        a = ~va;                              // must not disturb the operation
        b = ~vb;
        check({tag, " busy@E0"}, 32'(busy), 1);
        check({tag, " vld@E0"}, 32'(diff_bit_vld), 0);
        for (int i = 0; i < int'(W); i++) begin
            tick();                           // E(i+1)
            check($sformatf("%s vld bit%0d", tag, i), 32'(diff_bit_vld), 1);
            check($sformatf("%s diff_bit%0d", tag, i), 32'(diff_bit), 32'(ed[i]));
            check($sformatf("%s busy bit%0d", tag, i), 32'(busy), 1);
            if (i < int'(W) - 1) begin
                check($sformatf("%s done early bit%0d", tag, i), 32'(done), 0);
                check($sformatf("%s diff held bit%0d", tag, i), 32'(diff), 32'(last_diff));
                check($sformatf("%s borrow held bit%0d", tag, i), 32'(borrow_out), 32'(last_borrow));
            end else begin
                check({tag, " done"}, 32'(done), 1);
                check({tag, " diff"}, 32'(diff), 32'(ed));
                check({tag, " borrow_out"}, 32'(borrow_out), 32'(eb));
            end
        end
        tick();                               // E(W+1)
        check({tag, " busy end"}, 32'(busy), 0);
        check({tag, " done end"}, 32'(done), 0);
        check({tag, " vld end"}, 32'(diff_bit_vld), 0);
        check({tag, " diff hold"}, 32'(diff), 32'(ed));
        last_diff   = ed;
        last_borrow = eb;
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W-1:0] md;
        logic         mb;
        logic [W-1:0] f0;

        vecs[0] = '{8'h5A, 8'h23, 8'h37, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 8'hFF, 1'b1};
        vecs[2] = '{8'hA5, 8'hA5, 8'h00, 1'b0};
        vecs[3] = '{8'hFF, 8'h00, 8'hFF, 1'b0};
        vecs[4] = '{8'h80, 8'h7F, 8'h01, 1'b0};

        n_pass      = 0;
        n_total     = 0;
        last_diff   = '0;
        last_borrow = 1'b0;
        rst_n       = 1'b1;
        start       = 1'b0;
        a           = '0;
        b           = '0;

        // Reset values
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset");
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("idle busy %0d", i), 32'(busy), 0);
            check($sformatf("idle done %0d", i), 32'(done), 0);
        end

        // Table vectors 0..3 back-to-back (equal operands then FF-00)
        for (int i = 0; i < 4; i++) run_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb,
                                           vecs[i].exp_diff, vecs[i].exp_borrow);

        // Start held high, operands change after E3
        @(negedge clk);
        a = 8'h5A;
        b = 8'h23;
        start = 1'b1;
        tick();                               // E0
        check("held busy@E0", 32'(busy), 1);
        for (int e = 1; e <= 9; e++) begin
            tick();
            if (e == 3) begin
                a = 8'h10;
                b = 8'h20;
            end
            if (e == 8) begin
                check("held done1", 32'(done), 1);
                check("held diff1", 32'(diff), 32'h37);
                check("held borrow1", 32'(borrow_out), 0);
            end
            if (e == 9) begin
                check("held busy E9", 32'(busy), 0);
                check("held done E9", 32'(done), 0);
            end
        end
        tick();                               // E10 accepts the second op
        check("held busy E10", 32'(busy), 1);
        start = 1'b0;
        f0 = 8'hF0;
        for (int e = 11; e <= 18; e++) begin
            tick();
            check($sformatf("held2 diff_bit%0d", e - 11), 32'(diff_bit), 32'(f0[e - 11]));
            if (e == 18) begin
                check("held done2", 32'(done), 1);
                check("held diff2", 32'(diff), 32'hF0);
                check("held borrow2", 32'(borrow_out), 1);
            end else begin
                check($sformatf("held2 no done %0d", e), 32'(done), 0);
            end
        end
        tick();
        check("held2 busy end", 32'(busy), 0);
        last_diff   = 8'hF0;
        last_borrow = 1'b1;

        // Reset mid-operation between E4 and E5
        @(negedge clk);
        a = 8'hC3;
        b = 8'h3C;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e <= 4; e++) tick();
        #3 rst_n = 1'b0;
        #1 check_all_zero("midrst");
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("midrst done %0d", i), 32'(done), 0);
            check($sformatf("midrst busy %0d", i), 32'(busy), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        last_diff   = '0;
        last_borrow = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("postrst done %0d", i), 32'(done), 0);
            check($sformatf("postrst busy %0d", i), 32'(busy), 0);
        end
        run_op("vec4", vecs[4].va, vecs[4].vb, vecs[4].exp_diff, vecs[4].exp_borrow);

        // Random operands against arithmetic model
        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            md = W'((int'(ra) - int'(rb) + 256) % 256);
            mb = (ra < rb);
            run_op($sformatf("rand%0d", i), ra, rb, md, mb);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
